// File: rtl/program_memory_loader_pkg.sv
// Shared encodings for the program memory loader: FSM state codes, word packing constants
// and the payload checksum step.
package program_loader_pkg;

    localparam int BYTES_PER_WORD  = 4;
    localparam int WORD_ADDR_SHIFT = 2;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_CSUM  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERROR = 3'd6;

    // One step of the running payload XOR.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/program_memory_loader_packer.sv
// byte_word_packer: gathers four stream bytes LSB first into one 32-bit instruction word.
module byte_word_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  cnt_r;
    logic [31:0] shift_r;

    // The word including the byte currently offered, so the 4th byte is visible without a cycle of lag.
    assign word      = {byte_in, shift_r[31:8]};
    assign word_full = byte_en && (cnt_r == 2'(BYTES_PER_WORD - 1));

    // Byte counter and LSB-first shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r   <= 2'd0;
            shift_r <= 32'd0;
        end else if (clear) begin
            cnt_r   <= 2'd0;
            shift_r <= 32'd0;
        end else if (byte_en) begin
            cnt_r   <= cnt_r + 2'd1;
            shift_r <= word;
        end else begin
            cnt_r   <= cnt_r;
            shift_r <= shift_r;
        end
    end

endmodule

// File: rtl/program_memory_loader.sv
// program_memory_loader: writes a length-prefixed byte image into program RAM and holds the core
// in reset until it is complete. Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_memory_loader
    import program_loader_pkg::*;
#(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int LEN_WIDTH    = 16
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  cpu_hold_o
);

    localparam logic [LEN_WIDTH-1:0] DEPTH_L = LEN_WIDTH'(MEMORY_DEPTH);
    localparam logic [LEN_WIDTH-1:0] ONE_L   = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] ZERO_L  = LEN_WIDTH'(0);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t ST_FINAL = ST_CSUM;
`else
    localparam state_t ST_FINAL = ST_DONE;
`endif

    state_t                  state_r;
    state_t                  state_next_s;
    logic [LEN_WIDTH-1:0]    len_r;
    logic [7:0]              len_lo_r;
    logic                    len_phase_r;
    logic [LEN_WIDTH-1:0]    word_index_r;
    logic [LEN_WIDTH-1:0]    len_hdr_s;
    logic                    xfer_s;
    logic                    start_acc_s;
    logic                    pack_en_s;
    logic [31:0]             word_s;
    logic                    word_full_s;
    logic                    ready_next_s;
    logic                    busy_next_s;

    logic                    byte_ready_r;
    logic                    mem_we_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_data_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    err_r;
    logic                    cpu_hold_r;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              csum_r;

    // Running XOR of payload bytes; the header never contributes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_r <= 8'd0;
        end else if (start_acc_s) begin
            csum_r <= 8'd0;
        end else if (pack_en_s) begin
            csum_r <= csum_step(csum_r, byte_i);
        end else begin
            csum_r <= csum_r;
        end
    end
`endif

    assign xfer_s      = byte_valid_i && byte_ready_r;
    assign start_acc_s = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR));
    assign pack_en_s   = xfer_s && (state_r == ST_DATA);
    assign len_hdr_s   = LEN_WIDTH'({byte_i, len_lo_r});

    byte_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_acc_s),
        .byte_en   (pack_en_s),
        .byte_in   (byte_i),
        .word      (word_s),
        .word_full (word_full_s)
    );

    // Next-state decode for the load sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) state_next_s = ST_LEN;
                else         state_next_s = state_r;
            end
            ST_LEN: begin
                if (xfer_s && len_phase_r) begin
                    if (len_hdr_s == ZERO_L)       state_next_s = ST_FINAL;
                    else if (len_hdr_s > DEPTH_L)  state_next_s = ST_ERROR;
                    else                           state_next_s = ST_DATA;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DATA: begin
                if (word_full_s) state_next_s = ST_WRITE;
                else             state_next_s = state_r;
            end
            ST_WRITE: begin
                if (word_index_r + ONE_L == len_r) state_next_s = ST_FINAL;
                else                               state_next_s = ST_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (xfer_s) state_next_s = (byte_i == csum_r) ? ST_DONE : ST_ERROR;
                else        state_next_s = state_r;
            end
`endif
            default: state_next_s = ST_IDLE;
        endcase
    end

    assign ready_next_s = (state_next_s == ST_LEN) || (state_next_s == ST_DATA) || (state_next_s == ST_CSUM);
    assign busy_next_s  = ready_next_s || (state_next_s == ST_WRITE);

    // State, header length capture and word index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            len_r        <= ZERO_L;
            len_lo_r     <= 8'd0;
            len_phase_r  <= 1'b0;
            word_index_r <= ZERO_L;
        end else begin
            state_r <= state_next_s;
            if (start_acc_s) begin
                len_r        <= ZERO_L;
                len_lo_r     <= 8'd0;
                len_phase_r  <= 1'b0;
                word_index_r <= ZERO_L;
            end else if ((state_r == ST_LEN) && xfer_s) begin
                len_phase_r <= ~len_phase_r;
                if (len_phase_r) len_r    <= len_hdr_s;
                else             len_lo_r <= byte_i;
            end else if (state_r == ST_WRITE) begin
                word_index_r <= word_index_r + ONE_L;
            end else begin
                word_index_r <= word_index_r;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_ready_r <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_WIDTH{1'b0}};
            mem_data_r   <= {DATA_WIDTH{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            cpu_hold_r   <= 1'b0;
        end else begin
            byte_ready_r <= ready_next_s;
            mem_we_r     <= (state_next_s == ST_WRITE);
            busy_r       <= busy_next_s;
            done_r       <= (state_next_s == ST_DONE);
            err_r        <= (state_next_s == ST_ERROR);
            cpu_hold_r   <= busy_next_s || (state_next_s == ST_ERROR);
            if ((state_next_s == ST_WRITE) && (state_r == ST_DATA)) begin
                mem_addr_r <= ADDR_WIDTH'(word_index_r) << WORD_ADDR_SHIFT;
                mem_data_r <= DATA_WIDTH'(word_s);
            end else begin
                mem_addr_r <= mem_addr_r;
                mem_data_r <= mem_data_r;
            end
        end
    end

    assign byte_ready_o = byte_ready_r;
    assign mem_we_o     = mem_we_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_data_o   = mem_data_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign err_o        = err_r;
    assign cpu_hold_o   = cpu_hold_r;

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench for program_memory_loader: table of image shapes plus hand-written corner
// sequences, all compared against an image-level reference model.
module tb_program_memory_loader;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        cpu_hold_o;

    program_memory_loader #(
        .MEMORY_DEPTH (DEPTH),
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (32),
        .LEN_WIDTH    (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .cpu_hold_o   (cpu_hold_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0]  pay_q[$];
    logic [7:0]  stream_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    bit          exp_done;
    bit          exp_err;

    typedef struct {
        int n;
        int gap_pct;
        bit bad_csum;
        bit exp_done;
        bit exp_err;
        int exp_writes;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Capture every RAM write; the loader must not accept bytes while writing.
    always @(negedge clk) begin
        if (reset === 1'b1 && mem_we_o === 1'b1) begin
            wr_addr_q.push_back(mem_addr_o);
            wr_data_q.push_back(mem_data_o);
            check("ready_in_write", {31'd0, byte_ready_o}, 32'd0);
        end
    end

    // Reference model: image bytes -> expected writes and final status.
    task automatic build_image(input int n, input bit bad_csum);
        logic [7:0] x;
        x = 8'h00;
        stream_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
        stream_q.push_back(n[7:0]);
        stream_q.push_back(n[15:8]);
        if (n > DEPTH) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            exp_addr_q.push_back(32'(w * 4));
            exp_data_q.push_back({pay_q[4*w+3], pay_q[4*w+2], pay_q[4*w+1], pay_q[4*w]});
        end
        for (int i = 0; i < 4 * n; i++) begin
            stream_q.push_back(pay_q[i]);
            x = x ^ pay_q[i];
        end
`ifdef LOADER_CHECKSUM_EN
        stream_q.push_back(bad_csum ? (x ^ 8'h01) : x);
        exp_done = !bad_csum;
        exp_err  = bad_csum;
`else
        exp_done = 1'b1;
        exp_err  = 1'b0;
`endif
    endtask

    task automatic random_payload(input int n);
        pay_q.delete();
        if (n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) pay_q.push_back(8'($urandom));
        end
    endtask

    task automatic test1_payload();
        pay_q.delete();
        pay_q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int waited;
        bit taken;
        waited = 0;
        taken  = 1'b0;
        while (!taken && waited < 100) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                byte_valid_i = 1'b0;
                byte_i       = 8'($urandom);
            end else begin
                byte_valid_i = 1'b1;
                byte_i       = b;
            end
            @(negedge clk);
            taken = byte_valid_i && byte_ready_o;
            @(posedge clk);
            #1;
            waited++;
        end
        byte_valid_i = 1'b0;
        if (!taken) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_byte: byte 0x%0h not accepted within 100 cycles", b);
        end
    endtask

    task automatic wait_final();
        int c;
        c = 0;
        while (!(done_o || err_o) && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= 50) begin
            n_checks++;
            n_fails++;
            $display("FAIL wait_final: no done/err within 50 cycles");
        end
    endtask

    // Load the current stream_q and compare against the model's expectations.
    task automatic run_image(input string tag, input int gap_pct);
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        check({tag, " busy_after_start"}, {31'd0, busy_o}, 32'd1);
        check({tag, " hold_after_start"}, {31'd0, cpu_hold_o}, 32'd1);
        foreach (stream_q[i]) send_byte(stream_q[i], gap_pct);
        wait_final();
        @(posedge clk);
        #1;
        check({tag, " done"}, {31'd0, done_o}, {31'd0, exp_done});
        check({tag, " err"}, {31'd0, err_o}, {31'd0, exp_err});
        check({tag, " hold"}, {31'd0, cpu_hold_o}, {31'd0, exp_err});
        check({tag, " busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, " ready_idle"}, {31'd0, byte_ready_o}, 32'd0);
        check({tag, " nwrites"}, 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s addr[%0d]", tag, i), wr_addr_q[i], exp_addr_q[i]);
            check($sformatf("%s data[%0d]", tag, i), wr_data_q[i], exp_data_q[i]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ready"}, {31'd0, byte_ready_o}, 32'd0);
        check({tag, " we"}, {31'd0, mem_we_o}, 32'd0);
        check({tag, " addr"}, mem_addr_o, 32'd0);
        check({tag, " data"}, mem_data_o, 32'd0);
        check({tag, " flags"}, {28'd0, busy_o, done_o, err_o, cpu_hold_o}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1,     0,  1'b0, 1'b1, 1'b0, 1};
        vecs[1] = '{32,    25, 1'b0, 1'b1, 1'b0, 32};
        vecs[2] = '{33,    0,  1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{3,     50, 1'b0, 1'b1, 1'b0, 3};
        vecs[4] = '{0,     0,  1'b0, 1'b1, 1'b0, 0};
        vecs[5] = '{65535, 0,  1'b0, 1'b0, 1'b1, 0};
        vecs[6] = '{31,    10, 1'b0, 1'b1, 1'b0, 31};
`ifdef LOADER_CHECKSUM_EN
        vecs[7] = '{2,     0,  1'b1, 1'b0, 1'b1, 2};
`else
        vecs[7] = '{2,     0,  1'b1, 1'b1, 1'b0, 2};
`endif

        do_reset();
        check_all_zero("reset");

        // Reference image with exact known words.
        test1_payload();
        build_image(2, 1'b0);
        run_image("t1", 0);
        if (wr_data_q.size() == 2) begin
            check("t1 word0", wr_data_q[0], 32'h00100513);
            check("t1 word1", wr_data_q[1], 32'h00200593);
        end else begin
            check("t1 word_count", 32'(wr_data_q.size()), 32'd2);
        end

        // Same image with a stalling source.
        run_image("t2", 50);

        // Empty image completes without any write.
        wr_addr_q.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        @(posedge clk);
        #1;
        check("t3 done", {31'd0, done_o}, 32'd1);
        check("t3 hold", {31'd0, cpu_hold_o}, 32'd0);
        check("t3 nwrites", 32'(wr_addr_q.size()), 32'd0);

        // Table-driven image shapes.
        for (int v = 0; v < 8; v++) begin
            random_payload(vecs[v].n);
            build_image(vecs[v].n, vecs[v].bad_csum);
            run_image($sformatf("vec%0d", v), vecs[v].gap_pct);
            check($sformatf("vec%0d tbl_done", v), {31'd0, done_o}, {31'd0, vecs[v].exp_done});
            check($sformatf("vec%0d tbl_err", v), {31'd0, err_o}, {31'd0, vecs[v].exp_err});
            check($sformatf("vec%0d tbl_nwr", v), 32'(wr_addr_q.size()), 32'(vecs[v].exp_writes));
        end

        // start_i is ignored while a load is in progress.
        test1_payload();
        build_image(2, 1'b0);
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(stream_q[0], 0);
        send_byte(stream_q[1], 0);
        send_byte(stream_q[2], 0);
        pulse_start();
        for (int i = 3; i < stream_q.size(); i++) send_byte(stream_q[i], 0);
        wait_final();
        check("ign_start done", {31'd0, done_o}, 32'd1);
        check("ign_start nwrites", 32'(wr_addr_q.size()), 32'd2);

        // Asynchronous reset in the middle of a payload.
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(stream_q[i], 0);
        #2 reset = 1'b0;
        #1;
        check_all_zero("t5 async");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("t5 idle");
        run_image("t5 reload", 0);

        // Randomized images against the model.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(34));
            random_payload(n);
            build_image(n, ($urandom_range(3) == 0));
            run_image($sformatf("rnd%0d", r), int'($urandom_range(60)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
